snake_dir_ctrl: RTL and testbench

//  Upstream of the snake position/segment controller. Converts raw player buttons into a

---
 rtl/snake_dir_ctrl_pkg.sv | 46 ++++
 rtl/snake_dir_ctrl_btn_debounce.sv | 42 ++++
 rtl/snake_dir_ctrl.sv | 124 ++++++++++++
 tb/tb_snake_dir_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/snake_dir_ctrl_pkg.sv
// Shared encodings for the snake direction controller and the position controller downstream.
// Direction codes are fixed so that the opposite heading is always code ^ 2'b10.
package snake_dir_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  // Button lane order: the four directions by code, then pause.
  localparam int unsigned NUM_BTN   = 5;
  localparam int unsigned BTN_PAUSE = 4;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
  localparam int unsigned DEF_DB_W            = 18;
  localparam int unsigned DEF_MOVE_DIV        = 6250000;
  localparam int unsigned DEF_DIV_W           = 23;

  typedef struct packed {
    logic valid;
    dir_e d;
  } turn_t;

  function automatic dir_e reverse_of(input dir_e d);
    return dir_e'(d ^ 2'b10);
  endfunction

  // Highest-priority direction press only; lower ones are never a fallback.
  function automatic turn_t pick_turn(input logic [3:0] p);
    turn_t t;
    t = '{valid: 1'b0, d: DIR_UP};
    for (int i = 3; i >= 0; i--)
      if (p[i]) t = '{valid: 1'b1, d: dir_e'(2'(i))};
    return t;
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_btn_debounce.sv
// One button lane: 2-FF synchroniser, stability counter, and a one-cycle pulse on an
// accepted rising level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DB_W            = 18
) (
  input  logic Snake_clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            s1, s2, level;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge Snake_clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      // Any sample matching the accepted level restarts the count.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s2;
        cnt   <= '0;
        press <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Button-to-heading front end for the snake game: turn acceptance, run/pause/over
// sequencing and the move divider that produces move_tick.
module snake_dir_ctrl
  import snake_dir_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DB_W            = DEF_DB_W,
  parameter int unsigned MOVE_DIV        = DEF_MOVE_DIV,
  parameter int unsigned DIV_W           = DEF_DIV_W
) (
  input  logic       Snake_clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_pause,
  input  logic       game_over,
  output logic [1:0] dir,
  output logic       move_tick,
  output logic       paused,
  output logic       restart
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);

  logic [NUM_BTN-1:0] btn, press;

  assign btn = {btn_pause, btn_left, btn_down, btn_right, btn_up};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_db (
      .Snake_clk(Snake_clk),
      .rst      (rst),
      .raw      (btn[i]),
      .press    (press[i])
    );
  end

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d, pend_q, pend_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d, restart_q, restart_d;
  turn_t            turn;
  logic             take, pause_hit;

  assign turn      = pick_turn(press[3:0]);
  assign take      = turn.valid && (turn.d != reverse_of(dir_q));
  assign pause_hit = press[BTN_PAUSE];

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    pend_d    = pend_q;
    div_d     = div_q;
    tick_d    = 1'b0;
    restart_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (take) begin
          pend_d  = turn.d;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (take) pend_d = turn.d;
        // A collision suppresses the tick even when the divider is due to wrap.
        if (game_over) begin
          state_d = ST_OVER;
        end else if (pause_hit) begin
          state_d = ST_PAUSE;
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          tick_d = 1'b1;
          dir_d  = pend_q;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (game_over)      state_d = ST_OVER;
        else if (pause_hit) state_d = ST_RUN;
      end
      ST_OVER: begin
        div_d = '0;
        if (pause_hit) begin
          state_d   = ST_IDLE;
          restart_d = 1'b1;
          dir_d     = DIR_RIGHT;
          pend_d    = DIR_RIGHT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Snake_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_RIGHT;
      pend_q    <= DIR_RIGHT;
      div_q     <= '0;
      tick_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      pend_q    <= pend_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
      restart_q <= restart_d;
    end
  end

  assign dir       = dir_q;
  assign move_tick = tick_q;
  assign restart   = restart_q;
  assign paused    = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed + randomized bench for snake_dir_ctrl against a cycle-level reference model
// built from the window-of-samples debounce rule and the game rules.
module tb_snake_dir_ctrl;

  localparam int DB  = 4;
  localparam int MD  = 8;
  localparam int HW  = DB + 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVER = 3;

  logic       Snake_clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_pause = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] dir;
  logic       move_tick, paused, restart;

  int tests = 0;
  int fails = 0;

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .DB_W           (3),
    .MOVE_DIV       (MD),
    .DIV_W          (4)
  ) dut (
    .Snake_clk(Snake_clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_right(btn_right),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_pause(btn_pause),
    .game_over(game_over),
    .dir      (dir),
    .move_tick(move_tick),
    .paused   (paused),
    .restart  (restart)
  );

  always #5 Snake_clk = ~Snake_clk;

  // Reference model state
  bit hist [5][HW];   // raw samples, index 0 = newest edge
  bit m_lvl [5];
  bit m_press [5];
  int m_state, m_dir, m_pend, m_div;
  bit m_tick, m_restart;
  int n_ticks;

  task automatic model_reset();
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < HW; j++) hist[b][j] = 1'b0;
      m_lvl[b]   = 1'b0;
      m_press[b] = 1'b0;
    end
    m_state = M_IDLE; m_dir = 1; m_pend = 1; m_div = 0;
    m_tick = 1'b0; m_restart = 1'b0;
  endtask

  task automatic model_edge();
    bit raw [5];
    int sel, old_pend;
    bit acc, pz;
    raw[0] = btn_up; raw[1] = btn_right; raw[2] = btn_down; raw[3] = btn_left; raw[4] = btn_pause;
    sel = -1;
    for (int i = 3; i >= 0; i--) if (m_press[i]) sel = i;
    acc = (sel >= 0) && (sel != (m_dir ^ 2));
    pz  = m_press[4];
    old_pend = m_pend;
    m_tick = 1'b0; m_restart = 1'b0;
    case (m_state)
      M_IDLE: if (acc) begin m_pend = sel; m_state = M_RUN; end
      M_RUN: begin
        if (acc) m_pend = sel;
        if (game_over) m_state = M_OVER;
        else if (pz) m_state = M_PAUSE;
        else begin
          m_div++;
          if (m_div == MD) begin m_div = 0; m_tick = 1'b1; m_dir = old_pend; n_ticks++; end
        end
      end
      M_PAUSE: if (game_over) m_state = M_OVER; else if (pz) m_state = M_RUN;
      default: begin
        m_div = 0;
        if (pz) begin m_state = M_IDLE; m_restart = 1'b1; m_dir = 1; m_pend = 1; end
      end
    endcase
    // Level accepted once the last DB synchronised samples (raw two edges back) all differ from it.
    for (int b = 0; b < 5; b++) begin
      bit all_new;
      for (int j = HW - 1; j > 0; j--) hist[b][j] = hist[b][j-1];
      hist[b][0] = raw[b];
      all_new = 1'b1;
      for (int j = 2; j < HW; j++) if (hist[b][j] == m_lvl[b]) all_new = 1'b0;
      m_press[b] = 1'b0;
      if (all_new) begin
        m_lvl[b]   = ~m_lvl[b];
        m_press[b] = m_lvl[b];
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Snake_clk);
    model_edge();
    @(negedge Snake_clk);
    chk("dir", 32'(dir), 32'(m_dir));
    chk("move_tick", 32'(move_tick), 32'(m_tick));
    chk("paused", 32'(paused), 32'(m_state == M_PAUSE));
    chk("restart", 32'(restart), 32'(m_restart));
  endtask

  task automatic hold(input logic [4:0] m, input int n);
    {btn_pause, btn_left, btn_down, btn_right, btn_up} = m;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int t0, seg;
    logic [4:0] m;
    model_reset();
    n_ticks = 0;
    repeat (3) @(negedge Snake_clk);
    chk("rst_dir", 32'(dir), 32'd1);
    chk("rst_tick", 32'(move_tick), 32'd0);
    rst = 1'b1;

    hold(5'b00000, 50);                       // idle: no ticks, heading RIGHT
    chk("idle_no_ticks", 32'(n_ticks), 32'd0);

    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 5'b00001 : 5'b00000, 2);
    hold(5'b00000, 12);                       // bouncing UP never accepted
    chk("bounce_still_idle", 32'(n_ticks), 32'd0);

    hold(5'b00001, 10);                       // UP -> RUN, ticks with heading UP
    hold(5'b00000, 30);
    chk("up_ticks_seen", 32'(n_ticks > 0), 32'd1);
    chk("up_heading", 32'(dir), 32'd0);

    hold(5'b00010, 6); hold(5'b00000, 20);   // turn RIGHT
    hold(5'b01000, 6); hold(5'b00000, 20);   // LEFT reversal ignored
    chk("left_rejected", 32'(dir), 32'd1);
    hold(5'b00100, 2); hold(5'b01100, 4); hold(5'b01000, 3); hold(5'b00000, 20);
    chk("down_taken", 32'(dir), 32'd2);

    hold(5'b10000, 6); hold(5'b00000, 40);   // pause
    chk("pause_held", 32'(paused), 32'd1);
    t0 = n_ticks;
    hold(5'b10000, 6); hold(5'b00000, 20);   // resume
    chk("resume_ticks", 32'(n_ticks > t0), 32'd1);

    hold(5'b10000, 6);                        // game_over together with pause press
    game_over = 1'b1; step(); step(); game_over = 1'b0;
    hold(5'b00000, 20);
    t0 = n_ticks;
    hold(5'b00001, 6); hold(5'b00000, 20);   // presses ignored in OVER
    chk("over_no_ticks", 32'(n_ticks), 32'(t0));
    hold(5'b10000, 6); hold(5'b00000, 10);   // restart -> IDLE
    chk("restart_dir", 32'(dir), 32'd1);

    hold(5'b00100, 6); hold(5'b00000, 20);   // run DOWN, pause, then reset mid-debounce
    hold(5'b10000, 6); hold(5'b00000, 8);
    chk("paused_before_rst", 32'(paused), 32'(m_state == M_PAUSE));
    hold(5'b00010, 2);
    #2 rst = 1'b0;
    #1;
    chk("async_dir", 32'(dir), 32'd1);
    chk("async_tick", 32'(move_tick), 32'd0);
    chk("async_paused", 32'(paused), 32'd0);
    chk("async_restart", 32'(restart), 32'd0);
    model_reset();
    @(negedge Snake_clk);
    rst = 1'b1;
    hold(5'b00000, 10);

    for (seg = 0; seg < 400; seg++) begin
      m = 5'b00000;
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 3) == 0) m[b] = 1'b1;
      {btn_pause, btn_left, btn_down, btn_right, btn_up} = m;
      game_over = ($urandom_range(0, 19) == 0);
      step();
      game_over = 1'b0;
      hold(m, $urandom_range(0, 11));
    end
    hold(5'b00000, 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
